// File: rtl/fp8_pkg.sv
// Shared E4M3 constants, field layout and accumulator FSM states.
// Used by the FP8 multiplier datapath and the frame accumulator.
package fp8_pkg;
   localparam int          BIAS      = 7;
   localparam int          EXP_MAX   = 14;
   localparam int          FRAC_BITS = 9;
   localparam logic [16:0] MAX_MAG   = 17'd122880;

   typedef struct packed {
      logic       sign;
      logic [3:0] exp;
      logic [2:0] mant;
   } e4m3_t;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } acc_state_t;
endpackage

// File: rtl/fp8_e4m3_accumulator_if.sv
// Input term stream and frame-result handshake of the FP8 E4M3 accumulator.
interface fp8_e4m3_accumulator_if #(
   parameter int ACC_W = 28
);
   logic [7:0]              in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_last;
   logic signed [ACC_W-1:0] out_sum;
   logic [7:0]              out_count;
   logic                    out_sat;
   logic                    out_inf;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_sum, out_count, out_sat, out_inf, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_sum, out_count, out_sat, out_inf, out_valid
   );
endinterface

// File: rtl/fp8_e4m3_to_fixed.sv
// Combinational E4M3 -> signed fixed point (2^-9 LSB); exp=15 clamps to 240.0.
module fp8_e4m3_to_fixed
   import fp8_pkg::*;
(
   input  logic [7:0]          i_data,
   output logic signed [17:0]  o_term,
   output logic                o_inf
);
   // Fixed-point shift for a 1.mmm significand: exp - BIAS - 3 + FRAC_BITS
   localparam int SH_OFF = FRAC_BITS - BIAS - 3;

   e4m3_t       w_f;
   logic [3:0]  w_shamt;
   logic [16:0] w_mag;

   assign w_f     = e4m3_t'(i_data);
   assign w_shamt = 4'(int'(w_f.exp) + SH_OFF);

   always_comb begin
      w_mag = '0;
      o_inf = 1'b0;
      if (w_f.exp > 4'(EXP_MAX)) begin
         w_mag = MAX_MAG;
         o_inf = 1'b1;
      end else if (w_f.exp != 4'd0) begin
         w_mag = 17'({1'b1, w_f.mant}) << w_shamt;
      end
   end

   assign o_term = w_f.sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
endmodule

// File: rtl/fp8_e4m3_accumulator.sv
// Frame accumulator for E4M3 products: decode stage, saturating add stage,
// and a two-state FSM that holds each frame result until it is taken.
module fp8_e4m3_accumulator
   import fp8_pkg::*;
#(
   parameter int ACC_W = 28
) (
   input logic                   clk,
   input logic                   rst_n,
   fp8_e4m3_accumulator_if.slave bus
);
   localparam logic signed [ACC_W:0] LIM  = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] NLIM = -LIM;

   function automatic logic sat_hit(input logic signed [ACC_W:0] s);
      return (s > LIM) || (s < NLIM);
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
      if (s > LIM)
         return LIM[ACC_W-1:0];
      else if (s < NLIM)
         return NLIM[ACC_W-1:0];
      return s[ACC_W-1:0];
   endfunction

   acc_state_t              r_state;
   acc_state_t              w_state_nxt;
   logic                    w_in_ready;
   logic                    w_out_valid;
   logic                    w_clear;
   logic                    w_accept;
   logic                    w_last_p1;

   logic signed [17:0]      w_term;
   logic                    w_inf;

   logic                    r_vld_p1;
   logic                    r_last_p1;
   logic                    r_inf_p1;
   logic signed [17:0]      r_term_p1;

   logic signed [ACC_W:0]   w_sum_p2;
   logic signed [ACC_W-1:0] r_acc_p2;
   logic [7:0]              r_cnt_p2;
   logic                    r_sat_p2;
   logic                    r_inf_p2;

   fp8_e4m3_to_fixed u_dec (
      .i_data (bus.in_data),
      .o_term (w_term),
      .o_inf  (w_inf)
   );

   assign w_accept  = bus.in_valid && w_in_ready;
   assign w_last_p1 = r_vld_p1 && r_last_p1;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ACCUM;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ACCUM: begin
            // Stop taking terms once the frame's last term is in flight
            w_in_ready = !w_last_p1;
            if (w_last_p1)
               w_state_nxt = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_clear     = 1'b1;
               w_state_nxt = ACCUM;
            end
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   // Stage p1: decoded term
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_vld_p1 <= 1'b0;
      else
         r_vld_p1 <= w_accept;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_term_p1 <= w_term;
         r_last_p1 <= bus.in_last;
         r_inf_p1  <= w_inf;
      end
   end

   // Stage p2: saturating accumulate
   assign w_sum_p2 = {r_acc_p2[ACC_W-1], r_acc_p2}
                   + {{(ACC_W+1-18){r_term_p1[17]}}, r_term_p1};

   always_ff @(posedge clk) begin
      if (!rst_n || w_clear) begin
         r_acc_p2 <= '0;
         r_cnt_p2 <= '0;
         r_sat_p2 <= 1'b0;
         r_inf_p2 <= 1'b0;
      end else if (r_vld_p1) begin
         r_acc_p2 <= sat_clamp(w_sum_p2);
         r_sat_p2 <= r_sat_p2 | sat_hit(w_sum_p2);
         r_cnt_p2 <= (r_cnt_p2 == 8'hFF) ? 8'hFF : r_cnt_p2 + 8'd1;
         r_inf_p2 <= r_inf_p2 | r_inf_p1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_sum   = r_acc_p2;
   assign bus.out_count = r_cnt_p2;
   assign bus.out_sat   = r_sat_p2;
   assign bus.out_inf   = r_inf_p2;
endmodule

// File: tb/tb_fp8_e4m3_accumulator.sv
// Bench for fp8_e4m3_accumulator: directed frames plus random frames against
// a real-arithmetic reference of the E4M3 value and saturating frame sum.
module tb_fp8_e4m3_accumulator;
   localparam int     ACC_W = 20;
   localparam longint LIM   = (longint'(1) << (ACC_W - 1)) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp8_e4m3_accumulator_if #(.ACC_W(ACC_W)) bus ();

   fp8_e4m3_accumulator #(.ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   byte unsigned frm[$];

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Value of an E4M3 byte in units of 2^-9
   function automatic longint dec(input byte unsigned b);
      int  e = int'(b[6:3]);
      int  m = int'(b[2:0]);
      real mag;
      if (e == 0) return 0;
      if (e == 15) mag = 240.0;
      else         mag = (1.0 + m / 8.0) * (2.0 ** (e - 7));
      return (b[7] ? -1 : 1) * longint'(mag * 512.0);
   endfunction

   task automatic put(input byte unsigned d, input bit last);
      int n = 0;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic run_frame(input int gap_max, input int hold);
      longint s   = 0;
      int     c   = 0;
      bit     sa  = 0;
      bit     inf = 0;
      byte unsigned b;
      foreach (frm[i]) begin
         b = frm[i];
         s += dec(b);
         if (s > LIM)       begin s = LIM;  sa = 1; end
         else if (s < -LIM) begin s = -LIM; sa = 1; end
         if (c < 255) c++;
         if (b[6:3] == 4'hF) inf = 1;
      end
      foreach (frm[i]) begin
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
         put(frm[i], i == frm.size() - 1);
      end
      chk("lat1_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("lat2_out_valid", bus.out_valid, 1);
      // Offer a term during the hold; it must not be taken
      repeat (hold) begin
         bus.in_data  = 8'($urandom);
         bus.in_last  = 1'b0;
         bus.in_valid = 1'b1;
         chk("hold_out_valid", bus.out_valid, 1);
         chk("hold_in_ready", bus.in_ready, 0);
         chk("hold_sum", bus.out_sum, s);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("sum", bus.out_sum, s);
      chk("count", bus.out_count, c);
      chk("sat", bus.out_sat, sa);
      chk("inf", bus.out_inf, inf);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("xfer_out_valid", bus.out_valid, 0);
      chk("xfer_in_ready", bus.in_ready, 1);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_sum"}, bus.out_sum, 0);
      chk({tag, "_count"}, bus.out_count, 0);
      chk({tag, "_sat"}, bus.out_sat, 0);
      chk({tag, "_inf"}, bus.out_inf, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_idle("reset");

      frm = {8'h38, 8'h40, 8'hB8};          run_frame(0, 0);
      frm = {8'h01, 8'h80, 8'h00};          run_frame(1, 0);
      frm.delete(); repeat (5) frm.push_back(8'h77); run_frame(0, 1);
      frm.delete(); repeat (5) frm.push_back(8'hF7); run_frame(0, 0);
      frm = {8'h7F, 8'h38};                 run_frame(0, 2);
      frm = {8'h38};                        run_frame(0, 5);

      // Abort a frame mid-way
      put(8'h38, 1'b0);
      put(8'h40, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_idle("midrst");
      frm = {8'h38};                        run_frame(0, 0);

      // Abort while a result is pending
      put(8'h40, 1'b1);
      repeat (2) @(posedge clk);
      #1 chk("done_out_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_idle("donerst");

      // Count saturation with small terms
      frm.delete();
      repeat (260) frm.push_back({1'($urandom), 4'($urandom_range(0, 3)), 3'($urandom)});
      run_frame(0, 0);

      for (int f = 0; f < 40; f++) begin
         frm.delete();
         repeat ($urandom_range(1, 10)) begin
            if ($urandom_range(0, 1) == 1)
               frm.push_back(8'($urandom));
            else
               frm.push_back({1'($urandom), 4'($urandom_range(0, 8)), 3'($urandom)});
         end
         run_frame(2, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
